// File: rtl/core_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, PC step and default address width.
package core_fetch_pkg;

  localparam int DEFAULT_MEM_ADDR_WIDTH = 10;
  localparam int PC_INC                 = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous instruction buffer with clear, simultaneous push/pop and a look-ahead count.
module core_fetch_fifo #(
  parameter int  WIDTH = 42,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] next_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  assign next_count = clear ? '0 : (count + CNT_W'(do_push) - CNT_W'(do_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_count;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/core_fetch_unit.sv
// Fetch PC owner: issues req/gnt/rvalid reads, buffers instructions, handles redirects and flushes.
// Optional FETCH_MISALIGN_CHECK_EN: reject unaligned redirect targets and raise sticky misalign_o.
module core_fetch_unit
  import core_fetch_pkg::*;
#(
  parameter int                       MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
  parameter int                       INSTR_WIDTH    = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] BOOT_ADDR     = '0,
  parameter int                       FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_i,
  input  logic                      redirect_abs_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_offset_i,
  input  logic                      stall_i,
  output logic                      req_mem_prog_o,
  output logic [MEM_ADDR_WIDTH-1:0] addr_mem_prog_o,
  input  logic                      gnt_mem_prog_i,
  input  logic                      rvalid_mem_prog_i,
  input  logic [INSTR_WIDTH-1:0]    rdata_mem_prog_i,
  output logic                      instr_valid_o,
  output logic [INSTR_WIDTH-1:0]    instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i,
  output fetch_state_t              fsm_state
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                      misalign_o
`endif
);

  localparam int W     = MEM_ADDR_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // Handshakes: a memory request transfers on a cycle with req && gnt, and req/addr
  // stay stable until then; rvalid returns the single outstanding read no earlier than
  // the cycle after gnt; decode consumes the head on a cycle with instr_valid && instr_ready.

  fetch_state_t   state;
  fetch_state_t   state_next;
  logic [W-1:0]   pc;
  logic [W-1:0]   pc_next;
  logic [W-1:0]   out_addr;
  logic [W-1:0]   last_pc;
  logic           outstanding;
  logic           outstanding_next;

  logic [W-1:0]   base_pc;
  logic [W-1:0]   raw_target;
  logic [W-1:0]   target;
  logic           redirect_take;
  logic           fetch_block;

  logic           gnt_take;
  logic           rvalid_take;
  logic           fifo_push;
  logic           fifo_pop;
  logic [CNT_W-1:0] next_count;
  logic           can_fetch;

  // Relative targets are taken from the head, or from the last consumed PC when empty.
  assign base_pc    = instr_valid_o ? instr_pc_o : last_pc;
  assign raw_target = redirect_abs_i ? redirect_offset_i : (base_pc + redirect_offset_i);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_next;
  logic target_bad;

  assign target        = raw_target;
  assign target_bad    = |raw_target[1:0];
  assign redirect_take = redirect_i && !target_bad;
  assign misalign_next = redirect_i ? target_bad : misalign_q;
  assign fetch_block   = misalign_next;
  assign misalign_o    = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_next;
  end
`else
  localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};

  assign target        = raw_target & ALIGN_MASK;
  assign redirect_take = redirect_i;
  assign fetch_block   = 1'b0;
`endif

  assign gnt_take    = (state == ST_REQ) && gnt_mem_prog_i;
  assign rvalid_take = outstanding && rvalid_mem_prog_i;
  // A redirect wins over a same-cycle response push and a same-cycle consume.
  assign fifo_push   = rvalid_take && (state == ST_WAIT) && !redirect_take;
  assign fifo_pop    = instr_valid_o && instr_ready_i && !redirect_take;

  // Every transition into REQ leaves nothing outstanding, so buffer occupancy alone decides space.
  assign can_fetch = !stall_i && !fetch_block && (next_count < DEPTH_CNT);

  core_fetch_fifo #(
    .WIDTH (INSTR_WIDTH + W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect_take),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_data  ({rdata_mem_prog_i, out_addr}),
    .head_data  ({instr_o, instr_pc_o}),
    .head_valid (instr_valid_o),
    .next_count (next_count)
  );

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding;
    case (state)
      ST_IDLE: state_next = can_fetch ? ST_REQ : ST_HOLD;
      ST_REQ: begin
        if (gnt_take) begin
          outstanding_next = 1'b1;
          pc_next          = pc + W'(PC_INC);
          state_next       = redirect_take ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rvalid_take) begin
          outstanding_next = 1'b0;
          state_next       = can_fetch ? ST_REQ : ST_HOLD;
        end else if (redirect_take) begin
          state_next = ST_FLUSH;
        end
      end
      ST_HOLD: begin
        if (can_fetch) state_next = ST_REQ;
      end
      ST_FLUSH: begin
        if (rvalid_take) begin
          outstanding_next = 1'b0;
          state_next       = can_fetch ? ST_REQ : ST_HOLD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (redirect_take) pc_next = target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= BOOT_ADDR;
      out_addr    <= BOOT_ADDR;
      last_pc     <= BOOT_ADDR;
      outstanding <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      if (gnt_take) out_addr <= pc;
      if (fifo_pop) last_pc  <= instr_pc_o;
    end
  end

  assign req_mem_prog_o  = (state == ST_REQ);
  assign addr_mem_prog_o = pc;
  assign fsm_state       = state;

endmodule

// File: tb/tb_core_fetch_unit.sv
// Scoreboarded bench for core_fetch_unit: memory responder checks request addresses,
// instruction monitor checks consumed {pc, instr} pairs against expected queues.
module tb_core_fetch_unit;
  import core_fetch_pkg::*;

  localparam int W     = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 2;
  localparam logic [W-1:0] BOOT = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          redirect;
  logic          redirect_abs;
  logic [W-1:0]  redirect_offset;
  logic          stall;
  logic          req;
  logic [W-1:0]  addr;
  logic          gnt;
  logic          rvalid;
  logic [IW-1:0] rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [W-1:0]  instr_pc;
  logic          instr_ready;
  fetch_state_t  fsm_state;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign;
`endif

  core_fetch_unit #(
    .MEM_ADDR_WIDTH (W),
    .INSTR_WIDTH    (IW),
    .BOOT_ADDR      (BOOT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_i        (redirect),
    .redirect_abs_i    (redirect_abs),
    .redirect_offset_i (redirect_offset),
    .stall_i           (stall),
    .req_mem_prog_o    (req),
    .addr_mem_prog_o   (addr),
    .gnt_mem_prog_i    (gnt),
    .rvalid_mem_prog_i (rvalid),
    .rdata_mem_prog_i  (rdata),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .instr_ready_i     (instr_ready),
    .fsm_state         (fsm_state)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o        (misalign)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [W-1:0]    exp_addr_q[$];
  logic [W+IW-1:0] exp_q[$];

  int grants_left  = 0;
  int rvalid_delay = 0;
  bit gap_check    = 0;
  bit have_prev    = 0;
  int last_cyc     = 0;

  assign gnt = (grants_left != 0);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] mem_data(input logic [W-1:0] a);
    return 32'hA5C0_0000 | {22'd0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_fetch(input logic [W-1:0] a);
    exp_addr_q.push_back(a);
    exp_q.push_back({a, mem_data(a)});
  endtask

  task automatic exp_instr(input logic [W-1:0] a);
    exp_q.push_back({a, mem_data(a)});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check("queues_drained", 64'(exp_addr_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic wait_grants(input int target, input int max_cycles);
    int n = 0;
    while (grants_left > target && n < max_cycles) begin
      tick();
      n++;
    end
    check("grants_consumed", 64'(grants_left), 64'(target));
  endtask

  task automatic do_redirect(input logic abs_sel, input logic [W-1:0] off);
    redirect        = 1'b1;
    redirect_abs    = abs_sel;
    redirect_offset = off;
    tick();
    redirect        = 1'b0;
    redirect_abs    = 1'b0;
    redirect_offset = '0;
  endtask

  // memory responder: checks each accepted request address, returns data after rvalid_delay
  logic [W-1:0] resp_addr;
  logic [W-1:0] resp_exp;
  always begin
    @(negedge clk);
    if (rst_n && req && gnt) begin
      resp_addr = addr;
      if (exp_addr_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_req: got addr 0x%0h, expected no request (cycle %0d)", addr, cyc);
      end else begin
        resp_exp = exp_addr_q.pop_front();
        check("req_addr", 64'(resp_addr), 64'(resp_exp));
      end
      if (gap_check) begin
        if (have_prev) check("gnt_spacing", 64'(cyc - last_cyc), 64'd2);
        have_prev = 1'b1;
        last_cyc  = cyc;
      end
      @(posedge clk);
      #1;
      grants_left--;
      repeat (rvalid_delay) begin
        @(posedge clk);
        #1;
      end
      rvalid = 1'b1;
      rdata  = mem_data(resp_addr);
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rdata  = '0;
    end
  end

  // instruction monitor: compares every consumed head against the expected queue
  logic [W+IW-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_instr: got pc 0x%0h, expected no instruction (cycle %0d)", instr_pc, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(mon_exp[W+IW-1:IW]));
        check("instr_data", 64'(instr), 64'(mon_exp[IW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_abs    = 1'b0;
    redirect_offset = '0;
    stall           = 1'b0;
    instr_ready     = 1'b0;
    rvalid          = 1'b0;
    rdata           = '0;
    repeat (3) tick();

    // reset values
    check("rst_req", 64'(req), 64'd0);
    check("rst_addr", 64'(addr), 64'(BOOT));
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", 64'(misalign), 64'd0);
`endif

    // streaming: gnt always, rvalid next cycle, ready=1 -> 0,4,...,20 one per 2 cycles
    instr_ready = 1'b1;
    gap_check   = 1'b1;
    for (int i = 0; i < 6; i++) exp_fetch(W'(4 * i));
    grants_left = 6;
    rst_n       = 1'b1;
    wait_drain(100);
    gap_check = 1'b0;
    check("stream_next_addr", 64'(addr), 64'h18);

    // gnt withheld 3 cycles: req and addr stable, pc does not advance
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nognt_req", 64'(req), 64'd1);
      check("nognt_addr", 64'(addr), 64'h18);
    end
    exp_fetch(W'(24));
    grants_left = 1;
    wait_drain(50);

    // ready=0: exactly two fetches then req drops; ready=1 resumes
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_fetch(W'(28 + 4 * i));
    grants_left = 5;
    wait_grants(3, 50);
    repeat (4) tick();
    check("full_req", 64'(req), 64'd0);
    check("full_grants_left", 64'(grants_left), 64'd3);
    check("full_state", 64'(fsm_state), 64'(ST_HOLD));
    check("full_head_pc", 64'(instr_pc), 64'h1C);
    instr_ready = 1'b1;
    wait_drain(100);
    wait_grants(0, 20);

    // stall while request pending: held to gnt, then no new request
    stall = 1'b1;
    repeat (2) begin
      tick();
      check("stall_req_held", 64'(req), 64'd1);
      check("stall_addr_held", 64'(addr), 64'h30);
    end
    exp_fetch(W'(48));
    grants_left = 1;
    wait_grants(0, 20);
    repeat (4) tick();
    check("stall_no_req", 64'(req), 64'd0);
    check("stall_state", 64'(fsm_state), 64'(ST_HOLD));
    stall = 1'b0;
    exp_fetch(W'(52));
    grants_left = 1;
    wait_drain(50);

    // absolute redirect from REQ without gnt: addr switches next cycle
    instr_ready = 1'b0;
    do_redirect(1'b1, W'(16));
    check("abs_redirect_addr", 64'(addr), 64'h10);
    check("abs_redirect_req", 64'(req), 64'd1);
    exp_addr_q.push_back(W'(16));
    grants_left = 1;
    wait_grants(0, 20);
    repeat (2) tick();
    check("head_valid_0x10", 64'(instr_valid), 64'd1);
    check("head_pc_0x10", 64'(instr_pc), 64'h10);

    // relative redirect 0x10+0x3F0 wraps to 0; delayed in-flight response is dropped
    rvalid_delay = 4;
    exp_addr_q.push_back(W'(20));
    grants_left = 1;
    wait_grants(0, 20);
    do_redirect(1'b0, W'(10'h3F0));
    rvalid_delay = 0;
    check("rel_redirect_addr", 64'(addr), 64'h000);
    check("rel_redirect_flushed", 64'(instr_valid), 64'd0);
    check("rel_redirect_state", 64'(fsm_state), 64'(ST_FLUSH));
    repeat (5) tick();
    check("drop_fifo_empty", 64'(instr_valid), 64'd0);
    check("drop_req", 64'(req), 64'd1);
    check("drop_addr", 64'(addr), 64'h000);
    instr_ready = 1'b1;
    exp_fetch(W'(0));
    grants_left = 1;
    wait_drain(50);

    // fill buffer with 4, 8 then redirect to unaligned 0x102
    instr_ready = 1'b0;
    exp_addr_q.push_back(W'(4));
    exp_addr_q.push_back(W'(8));
    grants_left = 2;
    wait_grants(0, 30);
    repeat (3) tick();
    check("pre_misalign_state", 64'(fsm_state), 64'(ST_HOLD));
    do_redirect(1'b1, W'(10'h102));
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_set", 64'(misalign), 64'd1);
    check("misalign_req", 64'(req), 64'd0);
    check("misalign_head_pc", 64'(instr_pc), 64'h4);
    exp_instr(W'(4));
    exp_instr(W'(8));
    instr_ready = 1'b1;
    wait_drain(30);
    repeat (3) tick();
    check("misalign_no_fetch", 64'(req), 64'd0);
    check("misalign_sticky", 64'(misalign), 64'd1);
    do_redirect(1'b1, W'(10'h100));
    check("misalign_clear", 64'(misalign), 64'd0);
    check("aligned_req", 64'(req), 64'd1);
    check("aligned_addr", 64'(addr), 64'h100);
`else
    check("forced_align_addr", 64'(addr), 64'h100);
    check("forced_align_req", 64'(req), 64'd1);
    check("forced_align_flushed", 64'(instr_valid), 64'd0);
    instr_ready = 1'b1;
`endif
    exp_fetch(W'(10'h100));
    grants_left = 1;
    wait_drain(50);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
